ysyx_220053_fwd_scoreboard: RTL
===============================

YSYX_220053_FWD_SCOREBOARD -- requirements
Module: ysyx_220053_fwd_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, register address width.
REQ-002 SHALL have parameter DW, default 64, data width.
REQ-003 SHALL have parameter DEPTH, default 4 (min 2), number of tracked downstream stages; stage DEPTH-1 is writeback.
REQ-004 SHALL have parameter NSRC, default 2, number of source-operand lookup ports.
REQ-005 SHALL use one clock and a synchronous active-high reset; the ports are clk and rst.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid_i  in  1  decode-stage instruction valid
- issue_wen_i  in  1  instruction writes rd
- issue_rd_i  in  AW  destination register
- issue_lat_i  in  LW=$clog2(DEPTH)  first stage index whose stage data holds the result (ALU 0, load 1)
- adv_i  in  1  pipeline advances this cycle
- kill_i  in  DEPTH  per-stage squash
- stage_data_i  in  DEPTH*DW  result data at each stage, slice k is stage k
- src_addr_i  in  NSRC*AW  source register addresses
- src_rfdata_i  in  NSRC*DW  register file read data
- src_data_o  out  NSRC*DW  forwarded operands
- stall_o  out  1  decode must hold
- issue_accept_o  out  1  issue entered stage 0 this edge
- pending_o  out  DEPTH  entry valid bits

Function
REQ-007 SHALL hold DEPTH entries {valid, wen, rd, lat}; entry k describes the instruction in stage k.
REQ-008 SHALL compute all lookups combinationally, with zero-cycle latency from src_addr_i to src_data_o.
REQ-009 SHALL mark port j as matching entry k when entry k is valid, has wen=1, has rd equal to src j, and src j is not 0.
REQ-010 SHALL give the lowest-index (youngest) matching entry priority.
REQ-011 SHALL drive src_data_o[j] from stage_data_i[k] when the winning entry k has k >= lat.
- With no match, src_data_o[j] is src_rfdata_i[j].
- Register 0 always yields src_rfdata_i.
REQ-012 SHALL assert stall_o = issue_valid_i when any port's winning entry has k < lat; otherwise stall_o = 0.
- A younger not-ready match is never bypassed by an older ready match.
REQ-013 SHALL set issue_accept_o = issue_valid_i & ~stall_o & adv_i.
REQ-014 SHALL update entries on each edge when adv_i=1:
- entry[k+1] takes entry[k], with valid cleared if kill_i[k].
- entry[0] takes the issue fields if issue_accept_o, else a bubble (valid=0).
- entry[DEPTH-1] retires; its value is then visible through src_rfdata_i.
REQ-015 SHALL, when adv_i=0, hold all entries in place except that valid is cleared where kill_i[k]=1; issue_accept_o is 0 in this case.
REQ-016 SHALL make pending_o[k] equal entry[k].valid.
REQ-017 SHALL treat issue_lat_i >= DEPTH as DEPTH-1.

Reset
REQ-018 SHALL clear every entry valid bit on the edge where rst=1; rst overrides adv_i, issue and kill_i.
REQ-019 SHALL, after reset, drive pending_o=0 and stall_o=0, with src_data_o equal to src_rfdata_i.
REQ-020 SHALL, on reset mid-stall, discard the stalling entry so that no stall remains on the next cycle.

Configuration
REQ-021 SHALL provide stall_cnt_o (out, 32 bits) and stall_cycles counting when YSYX_220053_SB_PERF_EN is defined.
- The counter increments each cycle stall_o=1, saturates at 0xFFFFFFFF and is cleared by rst.
REQ-022 SHALL, without YSYX_220053_SB_PERF_EN, have neither the port nor the counter logic.

Structure
REQ-023 SHALL place the entry struct typedef and the LAT_ALU=0 / LAT_LOAD=1 constants in shared package ysyx_220053_pipe_pkg.
REQ-024 SHALL implement per-port lookup as one sub-module, ysyx_220053_fwd_lookup, instantiated NSRC times.

Verification
REQ-025 SHALL cover: after reset, issue add x5 (lat 0), adv=1, then lookup x5 with stage_data[0]=0x11 -> src_data=0x11, stall_o=0.
REQ-026 SHALL cover: ld x6 (lat 1) in stage 0, lookup x6 -> stall_o=1; next adv -> stall_o=0 and src_data=stage_data[1]; pending_o=4'b0010.
REQ-027 SHALL cover: x7 in stage 0 (data 0xA) and in stage 2 (data 0xB) -> 0xA selected.
REQ-028 SHALL cover: lookup of x0 while an entry with rd=0 and wen=1 is valid -> src_rfdata returned, no stall.
REQ-029 SHALL cover: kill_i=4'b0001 with adv=1 while a load in stage 0 causes a stall -> the entry is dropped, stall clears next cycle, pending_o[1]=0.
REQ-030 SHALL cover, with YSYX_220053_SB_PERF_EN: a 3-cycle load-use stall sequence -> stall_cnt_o=3; rst -> 0.

Source files
------------

// File: rtl/ysyx_220053_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_pipe_pkg
// Brief    : Shared pipeline-tracking types and latency constants.
// Revision : 1.0
// ============================================================================
package ysyx_220053_pipe_pkg;

    // Entry fields are sized for the widest supported configuration.
    // Narrower address and latency values are zero-extended into these fields.
    localparam int c_AW_MAX = 8;
    localparam int c_LW_MAX = 8;

    localparam logic [c_LW_MAX-1:0] LAT_ALU  = 8'd0;
    localparam logic [c_LW_MAX-1:0] LAT_LOAD = 8'd1;

    typedef struct packed {
        logic                valid;
        logic                wen;
        logic [c_AW_MAX-1:0] rd;
        logic [c_LW_MAX-1:0] lat;
    } sb_entry_t;

    // A matching entry is a live producer of a non-zero register.
    function automatic logic entry_hits(input sb_entry_t e, input logic [c_AW_MAX-1:0] src);
        return e.valid & e.wen & (e.rd == src) & (src != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_220053_fwd_lookup.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_fwd_lookup
// Brief    : One source-operand lookup: youngest producer wins, forward or busy.
// Revision : 1.0
// ============================================================================
module ysyx_220053_fwd_lookup
    import ysyx_220053_pipe_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  sb_entry_t [DEPTH-1:0]    i_entries,
    input  logic [AW-1:0]            i_src_addr,
    input  logic [DW-1:0]            i_rf_data,
    input  logic [DEPTH*DW-1:0]      i_stage_data,
    output logic [DW-1:0]            o_data,
    output logic                     o_busy
);

    logic [c_AW_MAX-1:0] w_src;

    always_comb begin
        w_src  = c_AW_MAX'(i_src_addr);
        o_data = i_rf_data;
        o_busy = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites last.
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (entry_hits(i_entries[k], w_src)) begin
                if (k >= int'(i_entries[k].lat)) begin
                    o_data = i_stage_data[k*DW +: DW];
                    o_busy = 1'b0;
                end else begin
                    o_data = i_rf_data;
                    o_busy = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_220053_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_fwd_scoreboard
// Brief    : Per-stage destination tracking with operand forwarding and
//            load-use stall. Optional stall counter: YSYX_220053_SB_PERF_EN.
// Revision : 1.0
// ============================================================================
module ysyx_220053_fwd_scoreboard
    import ysyx_220053_pipe_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int NSRC  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid_i,
    input  logic                         issue_wen_i,
    input  logic [AW-1:0]                issue_rd_i,
    input  logic [$clog2(DEPTH)-1:0]     issue_lat_i,
    input  logic                         adv_i,
    input  logic [DEPTH-1:0]             kill_i,
    input  logic [DEPTH*DW-1:0]          stage_data_i,
    input  logic [NSRC*AW-1:0]           src_addr_i,
    input  logic [NSRC*DW-1:0]           src_rfdata_i,
    output logic [NSRC*DW-1:0]           src_data_o,
    output logic                         stall_o,
    output logic                         issue_accept_o,
    output logic [DEPTH-1:0]             pending_o
`ifdef YSYX_220053_SB_PERF_EN
    ,
    output logic [31:0]                  stall_cnt_o
`endif
);

    sb_entry_t [DEPTH-1:0] r_entries;
    sb_entry_t             w_issue;
    logic [c_LW_MAX-1:0]   w_lat;
    logic [NSRC-1:0]       w_busy;

    // Latencies beyond the tracked window resolve at writeback.
    always_comb begin
        if (32'(issue_lat_i) >= 32'(DEPTH)) begin
            w_lat = c_LW_MAX'(DEPTH-1);
        end else begin
            w_lat = c_LW_MAX'(issue_lat_i);
        end
        w_issue = '{valid: 1'b1, wen: issue_wen_i, rd: c_AW_MAX'(issue_rd_i), lat: w_lat};
    end

    for (genvar j = 0; j < NSRC; j++) begin : g_lookup
        ysyx_220053_fwd_lookup #(
            .AW    (AW),
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_lookup (
            .i_entries    (r_entries),
            .i_src_addr   (src_addr_i[j*AW +: AW]),
            .i_rf_data    (src_rfdata_i[j*DW +: DW]),
            .i_stage_data (stage_data_i),
            .o_data       (src_data_o[j*DW +: DW]),
            .o_busy       (w_busy[j])
        );
    end

    assign stall_o        = issue_valid_i & (|w_busy);
    assign issue_accept_o = issue_valid_i & ~stall_o & adv_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entries <= '0;
        end else if (adv_i) begin
            r_entries[0] <= issue_accept_o ? w_issue : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_entries[k]       <= r_entries[k-1];
                r_entries[k].valid <= r_entries[k-1].valid & ~kill_i[k-1];
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (kill_i[k]) begin
                    r_entries[k].valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            pending_o[k] = r_entries[k].valid;
        end
    end

`ifdef YSYX_220053_SB_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stall_o && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cycles;
`endif

endmodule
`default_nettype wire
